// File: rtl/riscv_trace_buffer.sv
// Circular writeback trace buffer with PC trigger and registered index/field readout.
// Define RISCV_TRACE_TIMESTAMP_EN to store a 16-bit cycle timestamp with each record.
module riscv_trace_buffer #(
    parameter int PC_W      = 9,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_half,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              reg_write_sig,
    input  logic [4:0]        reg_num,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              arm,
    input  logic              trig_en,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic [AW-1:0]     rd_idx,
    input  logic [1:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        state,
    output logic [CW-1:0]     count,
    output logic              triggered
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_n;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_n;
    logic [CW-1:0]     count_q, count_n;
    logic [AW-1:0]     post_q, post_n;
    logic              trig_q, trig_n;
    logic              capture;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [5:0]        wr_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [AW-1:0]     rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_field;

    assign state     = state_q;
    assign count     = count_q;
    assign triggered = trig_q;

    // arm takes priority over any sample in the same cycle
    assign capture = enable_half && !arm && (state_q == ARMED || state_q == POST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            wr_ptr_q <= wr_ptr_n;
            count_q  <= count_n;
            post_q   <= post_n;
            trig_q   <= trig_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        wr_ptr_n = wr_ptr_q;
        count_n  = count_q;
        post_n   = post_q;
        trig_n   = trig_q;
        if (arm) begin
            state_n  = ARMED;
            wr_ptr_n = '0;
            count_n  = '0;
            post_n   = '0;
            trig_n   = 1'b0;
        end else if (capture) begin
            wr_ptr_n = wr_ptr_q + AW'(1);
            if (count_q != CW'(DEPTH))
                count_n = count_q + CW'(1);
            case (state_q)
                ARMED: begin
                    if (trig_en && pc_in == trig_pc) begin
                        trig_n  = 1'b1;
                        post_n  = AW'(POST_TRIG);
                        state_n = (POST_TRIG == 0) ? DONE : POST;
                    end
                end
                POST: begin
                    post_n = post_q - AW'(1);
                    if (post_q == AW'(1))
                        state_n = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && capture) begin
            pc_mem[wr_ptr_q]   <= pc_in;
            wr_mem[wr_ptr_q]   <= {reg_write_sig, reg_num};
            data_mem[wr_ptr_q] <= reg_data;
        end
    end

`ifdef RISCV_TRACE_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset)
            ts_q <= '0;
        else
            ts_q <= ts_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset && capture)
            ts_mem[wr_ptr_q] <= ts_q;
    end
`endif

    // once the buffer has wrapped, the oldest record sits at the write pointer
    assign rd_addr  = (count_q == CW'(DEPTH)) ? (wr_ptr_q + rd_idx) : rd_idx;
    assign rd_valid = {1'b0, rd_idx} < count_q;

    always_comb begin
        rd_field = '0;
        case (rd_sel)
            2'd0: rd_field = DATA_W'(pc_mem[rd_addr]);
            2'd1: rd_field = DATA_W'(wr_mem[rd_addr]);
            2'd2: rd_field = data_mem[rd_addr];
            default: begin
`ifdef RISCV_TRACE_TIMESTAMP_EN
                rd_field = DATA_W'(ts_mem[rd_addr]);
`else
                rd_field = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)
            rd_data <= '0;
        else
            rd_data <= rd_valid ? rd_field : '0;
    end

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed self-checking bench for riscv_trace_buffer (default parameters).
module tb_riscv_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_half;
    logic [8:0]  pc_in;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        arm;
    logic        trig_en;
    logic [8:0]  trig_pc;
    logic [3:0]  rd_idx;
    logic [1:0]  rd_sel;
    logic [31:0] rd_data;
    logic [1:0]  state;
    logic [4:0]  count;
    logic        triggered;

    int tests = 0;
    int fails = 0;

    riscv_trace_buffer #(
        .PC_W(9), .DATA_W(32), .DEPTH(16), .POST_TRIG(8)
    ) dut (
        .clk(clk), .reset(reset), .enable_half(enable_half), .pc_in(pc_in),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_idx(rd_idx), .rd_sel(rd_sel), .rd_data(rd_data),
        .state(state), .count(count), .triggered(triggered)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [8:0] pc);
        enable_half = 1'b1;
        pc_in = pc;
        tick();
        enable_half = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic rd(input int idx, input int sel, input logic [31:0] exp, input string tag);
        rd_idx = idx[3:0];
        rd_sel = sel[1:0];
        tick();
        check(tag, rd_data, exp);
    endtask

    initial begin
        reset = 1'b0; enable_half = 1'b0; pc_in = '0; reg_write_sig = 1'b0;
        reg_num = '0; reg_data = '0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0;
        rd_idx = '0; rd_sel = '0;

        // reset then idle
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_trig", 32'(triggered), 32'd0);
        check("rst_rdata", rd_data, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) sample(9'(i));
        check("idle_state", 32'(state), 32'd0);
        check("idle_count", 32'(count), 32'd0);
        for (int s = 0; s < 4; s++) begin
            rd(0, s, 32'd0, "idle_rd0");
            rd(5, s, 32'd0, "idle_rd5");
        end

        // fill and wrap without trigger
        do_arm();
        reg_write_sig = 1'b1;
        for (int i = 0; i < 20; i++) begin
            reg_num = 5'(i);
            reg_data = 32'(i);
            sample(9'(16 + i));
        end
        check("fill_state", 32'(state), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        rd(0, 0, 32'h14, "fill_old_pc");
        rd(15, 0, 32'h23, "fill_new_pc");
        rd(0, 2, 32'd4, "fill_old_data");
        rd(15, 1, 32'h33, "fill_new_wr");

        // trigger plus post-trigger window
        do_arm();
        trig_pc = 9'h40;
        trig_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            sample(9'(9'h30 + i));
            if (i == 15) check("pre_trig", 32'(triggered), 32'd0);
            if (i == 16) begin
                check("trig_hit", 32'(triggered), 32'd1);
                check("trig_state", 32'(state), 32'd2);
            end
            if (i == 23) check("post_last", 32'(state), 32'd2);
            if (i == 24) check("done_state", 32'(state), 32'd3);
        end
        check("done_count", 32'(count), 32'd16);
        check("done_trig", 32'(triggered), 32'd1);
        rd(0, 0, 32'h39, "done_oldest");
        rd(7, 0, 32'h40, "done_trig_rec");
        rd(15, 0, 32'h48, "done_newest");
        trig_en = 1'b0;

        // gated capture
        do_arm();
        reg_num = 5'd5;
        reg_data = 32'hDEADBEEF;
        reg_write_sig = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enable_half = (i % 2 == 0);
            pc_in = 9'(9'h100 + i);
            tick();
        end
        enable_half = 1'b0;
        check("gate_count", 32'(count), 32'd2);
        rd(1, 1, 32'h25, "gate_wr");
        rd(1, 2, 32'hDEADBEEF, "gate_data");
        rd(1, 0, 32'h102, "gate_pc");
        rd(2, 0, 32'd0, "gate_oob");
`ifndef RISCV_TRACE_TIMESTAMP_EN
        rd(0, 3, 32'd0, "gate_no_ts");
`endif

        // re-arm collision and reset abort
        do_arm();
        trig_pc = 9'h40;
        trig_en = 1'b1;
        sample(9'h40);
        check("coll_pre_trig", 32'(triggered), 32'd1);
        arm = 1'b1;
        sample(9'h40);
        arm = 1'b0;
        check("coll_trig", 32'(triggered), 32'd0);
        check("coll_state", 32'(state), 32'd1);
        check("coll_count", 32'(count), 32'd0);
        sample(9'h40);
        check("abort_pre", 32'(state), 32'd2);
        reset = 1'b0;
        tick();
        check("abort_state", 32'(state), 32'd0);
        check("abort_trig", 32'(triggered), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        trig_en = 1'b0;

`ifdef RISCV_TRACE_TIMESTAMP_EN
        // counter reads 0 before the first released edge, so samples 5..7 see 4..6
        reset = 1'b1;
        tick(); tick(); tick();
        do_arm();
        sample(9'h1); sample(9'h2); sample(9'h3);
        rd(0, 3, 32'd4, "ts0");
        rd(1, 3, 32'd5, "ts1");
        rd(2, 3, 32'd6, "ts2");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
